// File: rtl/div_issue_ctrl.sv
// Issue/retire controller in front of the iterative radix-2 divider: it registers one request, runs DIV and returns the result.
// Optional DIV_ZERO_FAST_EN: a zero divisor skips DIV and returns a result one cycle after accept.
module div_issue_ctrl #(
  parameter int TAG_W = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       in_op,
  input  logic [31:0]      in_x,
  input  logic [31:0]      in_y,
  input  logic [TAG_W-1:0] in_tag,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_data,
  output logic [TAG_W-1:0] out_tag,
  output logic             busy,
  output logic             div_en,
  output logic             div_sign,
  output logic [31:0]      div_num,
  output logic [31:0]      div_den,
  output logic             div_resetn,
  input  logic [63:0]      div_result,
  input  logic             div_complete
);

  typedef enum logic [1:0] {IDLE, RUN, DONE, CLR} state_t;

  state_t           state_reg, state_next;
  logic [1:0]       op_reg;
  logic [31:0]      x_reg, y_reg;
  logic [TAG_W-1:0] tag_reg;
  logic [31:0]      out_data_reg;
  logic [TAG_W-1:0] out_tag_reg;
  logic             accept;
  logic             zero_fast;

  assign in_ready = ~flush & ((state_reg == IDLE) | ((state_reg == DONE) & out_ready));
  assign accept   = in_valid & in_ready;

`ifdef DIV_ZERO_FAST_EN
  assign zero_fast = accept & (in_y == 32'd0);
`else
  assign zero_fast = 1'b0;
`endif

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: begin
        if (accept) state_next = zero_fast ? DONE : RUN;
      end
      RUN: begin
        if (flush)             state_next = CLR;
        else if (div_complete) state_next = DONE;
      end
      DONE: begin
        if (flush)          state_next = CLR;
        else if (out_ready) state_next = accept ? (zero_fast ? DONE : RUN) : IDLE;
      end
      CLR: begin
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg <= IDLE;
      op_reg    <= 2'b00;
      x_reg     <= 32'd0;
      y_reg     <= 32'd0;
      tag_reg   <= '0;
    end else begin
      state_reg <= state_next;
      if (accept) begin
        op_reg  <= in_op;
        x_reg   <= in_x;
        y_reg   <= in_y;
        tag_reg <= in_tag;
      end
    end
  end

  // A flush in the completion cycle wins: the result is never latched.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_data_reg <= 32'd0;
      out_tag_reg  <= '0;
    end else if (zero_fast) begin
      out_data_reg <= in_op[0] ? in_x : 32'd0;
      out_tag_reg  <= in_tag;
    end else if ((state_reg == RUN) && div_complete && !flush) begin
      out_data_reg <= op_reg[0] ? div_result[31:0] : div_result[63:32];
      out_tag_reg  <= tag_reg;
    end
  end

  assign out_valid  = (state_reg == DONE);
  assign out_data   = out_data_reg;
  assign out_tag    = out_tag_reg;
  assign busy       = (state_reg != IDLE);
  assign div_en     = (state_reg == RUN);
  assign div_sign   = ~op_reg[1];
  assign div_num    = x_reg;
  assign div_den    = y_reg;
  // DIV sits in reset with us, and for the single CLR cycle after a flush.
  assign div_resetn = ~reset & (state_reg != CLR);

endmodule

// File: tb/tb_div_issue_ctrl.sv
// Self-checking bench for div_issue_ctrl with a cycle-accurate stand-in for the 34-cycle DIV.
// Build with +define+DIV_ZERO_FAST_EN to exercise the zero-divisor shortcut.
module tb_div_issue_ctrl;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [1:0]  in_op = 2'b00;
  logic [31:0] in_x = 32'd0;
  logic [31:0] in_y = 32'd0;
  logic [4:0]  in_tag = 5'd0;
  logic        flush = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] out_data;
  logic [4:0]  out_tag;
  logic        busy;
  logic        div_en;
  logic        div_sign;
  logic [31:0] div_num;
  logic [31:0] div_den;
  logic        div_resetn;
  logic [63:0] div_result;
  logic        div_complete;

  int checks = 0;
  int failures = 0;
  int div_en_cycles = 0;

  always #5 clk = ~clk;

  div_issue_ctrl #(.TAG_W(5)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
    .in_x(in_x), .in_y(in_y), .in_tag(in_tag), .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_tag(out_tag),
    .busy(busy), .div_en(div_en), .div_sign(div_sign), .div_num(div_num), .div_den(div_den),
    .div_resetn(div_resetn), .div_result(div_result), .div_complete(div_complete)
  );

  // Arithmetic of the divider: {quotient, remainder}, truncating division.
  function automatic logic [63:0] div_arith(input logic sgn, input logic [31:0] n, input logic [31:0] d);
    logic [31:0] q, r;
    if (d == 32'd0) begin
      q = 32'hFFFF_FFFF; r = n;
    end else if (sgn && n == 32'h8000_0000 && d == 32'hFFFF_FFFF) begin
      q = 32'h8000_0000; r = 32'd0;
    end else if (sgn) begin
      q = 32'($signed(n) / $signed(d)); r = 32'($signed(n) % $signed(d));
    end else begin
      q = n / d; r = n % d;
    end
    return {q, r};
  endfunction

  // DIV stand-in: complete in the 34th enabled cycle, counter self-clears then.
  logic [5:0] div_cnt;
  always_ff @(posedge clk) begin
    if (!div_resetn)  div_cnt <= 6'd0;
    else if (div_en)  div_cnt <= (div_cnt == 6'd33) ? 6'd0 : div_cnt + 6'd1;
  end
  assign div_complete = div_en && div_resetn && (div_cnt == 6'd33);
  assign div_result   = div_arith(div_sign, div_num, div_den);

  always @(posedge clk) if (div_en) div_en_cycles <= div_en_cycles + 1;

  function automatic logic [31:0] ref_res(input logic [1:0] op, input logic [31:0] x, input logic [31:0] y);
    logic [63:0] qr;
`ifdef DIV_ZERO_FAST_EN
    if (y == 32'd0) return op[0] ? x : 32'd0;
`endif
    qr = div_arith(~op[1], x, y);
    return op[0] ? qr[31:0] : qr[63:32];
  endfunction

  function automatic int ref_lat(input logic [31:0] y);
`ifdef DIV_ZERO_FAST_EN
    if (y == 32'd0) return 1;
`endif
    return 35;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic wait_out(output int lat);
    lat = 1;
    while (!out_valid && lat < 100) begin @(posedge clk); #1; lat++; end
  endtask

  // Issue one request with out_ready=1; returns cycles from accept to out_valid.
  task automatic do_op(input logic [1:0] op, input logic [31:0] x, input logic [31:0] y,
                       input logic [4:0] tag, output int lat, output logic [31:0] d, output logic [4:0] t);
    int n;
    in_valid = 1'b1; in_op = op; in_x = x; in_y = y; in_tag = tag; out_ready = 1'b1;
    #1; n = 0;
    while (!in_ready && n < 100) begin @(posedge clk); #1; n++; end
    @(posedge clk); #1;
    in_valid = 1'b0;
    wait_out(lat);
    d = out_data; t = out_tag;
    $display("op=%0d x=0x%08h y=0x%08h tag=%0d -> data=0x%08h tag=%0d lat=%0d", op, x, y, tag, d, t, lat);
    @(posedge clk); #1;
  endtask

  typedef struct {
    logic [1:0]  op;
    logic [31:0] x;
    logic [31:0] y;
    logic [4:0]  tag;
    logic [31:0] exp;
  } vec_t;

  typedef struct {
    logic [31:0] data;
    logic [4:0]  tag;
    int          due;
    bit          seen;
  } exp_t;

  initial begin
    vec_t        vecs[7];
    exp_t        sb[$];
    exp_t        e;
    int          lat, n, base, cnt;
    logic [31:0] d;
    logic [4:0]  t;
    bit          took;

    vecs[0] = '{2'b00, 32'hFFFF_FFF9, 32'd2,          5'd1,  32'hFFFF_FFFD};
    vecs[1] = '{2'b01, 32'hFFFF_FFF9, 32'd2,          5'd2,  32'hFFFF_FFFF};
    vecs[2] = '{2'b10, 32'hFFFF_FFF9, 32'd2,          5'd3,  32'h7FFF_FFFC};
    vecs[3] = '{2'b11, 32'd100,       32'd7,          5'd4,  32'd2};
    vecs[4] = '{2'b00, 32'd100,       32'd7,          5'd5,  32'd14};
    vecs[5] = '{2'b01, 32'h8000_0000, 32'd3,          5'd6,  32'hFFFF_FFFE};
    vecs[6] = '{2'b10, 32'hFFFF_FFFF, 32'd1,          5'd31, 32'hFFFF_FFFF};

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_out_data", 64'(out_data), 64'd0);
    check("rst_out_tag", 64'(out_tag), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_div_en", 64'(div_en), 64'd0);
    check("rst_div_resetn", 64'(div_resetn), 64'd0);
    reset = 1'b0;
    #1;
    check("idle_in_ready", 64'(in_ready), 64'd1);
    check("idle_div_resetn", 64'(div_resetn), 64'd1);
    @(posedge clk); #1;

    // Directed vectors
    for (int i = 0; i < 7; i++) begin
      do_op(vecs[i].op, vecs[i].x, vecs[i].y, vecs[i].tag, lat, d, t);
      check($sformatf("vec%0d_latency", i), 64'(lat), 64'd35);
      check($sformatf("vec%0d_data", i), 64'(d), 64'(vecs[i].exp));
      check($sformatf("vec%0d_tag", i), 64'(t), 64'(vecs[i].tag));
    end

    // Flush while idle only blocks acceptance that cycle
    in_valid = 1'b1; in_op = 2'b00; in_x = 32'd9; in_y = 32'd3; in_tag = 5'd1; flush = 1'b1;
    #1;
    check("idle_flush_in_ready", 64'(in_ready), 64'd0);
    @(posedge clk); #1;
    in_valid = 1'b0; flush = 1'b0;
    #1;
    check("idle_flush_busy", 64'(busy), 64'd0);

    // Backpressure then back-to-back accept
    in_valid = 1'b1; in_op = 2'b00; in_x = 32'hFFFF_FFF9; in_y = 32'd2; in_tag = 5'd3; out_ready = 1'b0;
    #1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    wait_out(lat);
    check("bp_latency", 64'(lat), 64'd35);
    in_valid = 1'b1; in_op = 2'b00; in_x = 32'd100; in_y = 32'd7; in_tag = 5'd4;
    #1;
    for (int i = 0; i < 5; i++) begin
      check("bp_out_valid", 64'(out_valid), 64'd1);
      check("bp_data", 64'(out_data), 64'hFFFF_FFFD);
      check("bp_tag", 64'(out_tag), 64'd3);
      check("bp_in_ready", 64'(in_ready), 64'd0);
      @(posedge clk); #2;
    end
    out_ready = 1'b1;
    #1;
    check("b2b_in_ready", 64'(in_ready), 64'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    wait_out(lat);
    check("b2b_latency", 64'(lat), 64'd35);
    check("b2b_data", 64'(out_data), 64'd14);
    check("b2b_tag", 64'(out_tag), 64'd4);
    $display("b2b result data=0x%08h tag=%0d lat=%0d", out_data, out_tag, lat);
    @(posedge clk); #1;

    // Flush on the 10th RUN cycle
    in_valid = 1'b1; in_op = 2'b00; in_x = 32'd100; in_y = 32'd7; in_tag = 5'd9;
    #1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (9) begin @(posedge clk); #1; end
    flush = 1'b1;
    #1;
    check("flush_in_ready", 64'(in_ready), 64'd0);
    check("flush_busy", 64'(busy), 64'd1);
    @(posedge clk); #1;
    flush = 1'b0;
    #1;
    check("clr_div_resetn", 64'(div_resetn), 64'd0);
    check("clr_div_en", 64'(div_en), 64'd0);
    check("clr_out_valid", 64'(out_valid), 64'd0);
    @(posedge clk); #1;
    check("post_clr_div_resetn", 64'(div_resetn), 64'd1);
    check("post_clr_busy", 64'(busy), 64'd0);
    do_op(2'b00, 32'd100, 32'd7, 5'd10, lat, d, t);
    check("post_flush_latency", 64'(lat), 64'd35);
    check("post_flush_data", 64'(d), 64'd14);
    check("post_flush_tag", 64'(t), 64'd10);

    // Asynchronous reset mid-RUN
    in_valid = 1'b1; in_op = 2'b01; in_x = 32'd55; in_y = 32'd6; in_tag = 5'd12;
    #1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (5) begin @(posedge clk); #1; end
    #1;
    reset = 1'b1;
    #1;
    check("arst_out_valid", 64'(out_valid), 64'd0);
    check("arst_busy", 64'(busy), 64'd0);
    check("arst_div_en", 64'(div_en), 64'd0);
    check("arst_div_resetn", 64'(div_resetn), 64'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    cnt = 0;
    for (int i = 0; i < 40; i++) begin
      if (out_valid) cnt++;
      @(posedge clk); #1;
    end
    check("arst_no_result", 64'(cnt), 64'd0);

    // Zero divisor
    base = div_en_cycles;
    do_op(2'b01, 32'h1234_5678, 32'd0, 5'd7, lat, d, t);
`ifdef DIV_ZERO_FAST_EN
    check("zero_mod_latency", 64'(lat), 64'd1);
    check("zero_mod_div_en_cycles", 64'(div_en_cycles - base), 64'd0);
`else
    check("zero_mod_latency", 64'(lat), 64'd35);
    check("zero_mod_div_en_cycles", 64'(div_en_cycles - base), 64'd34);
`endif
    check("zero_mod_data", 64'(d), 64'h1234_5678);
    check("zero_mod_tag", 64'(t), 64'd7);
    do_op(2'b00, 32'd5, 32'd0, 5'd8, lat, d, t);
    check("zero_div_latency", 64'(lat), 64'(ref_lat(32'd0)));
`ifdef DIV_ZERO_FAST_EN
    check("zero_div_data", 64'(d), 64'd0);
`else
    check("zero_div_data", 64'(d), 64'hFFFF_FFFF);
`endif

    // Randomized traffic against the scoreboard
    in_valid = 1'b0; took = 1'b0;
    for (int k = 0; k < 3000; k++) begin
      if (!in_valid || took) begin
        in_valid = ($urandom_range(0, 2) != 0);
        in_op = 2'($urandom);
        in_x = $urandom;
        case ($urandom_range(0, 15))
          0:       in_y = 32'd0;
          1, 2, 3: in_y = 32'($urandom_range(1, 9));
          4:       in_y = 32'hFFFF_FFFF;
          default: in_y = $urandom;
        endcase
        in_tag = 5'($urandom);
      end
      out_ready = ($urandom_range(0, 3) != 0);
      flush = ($urandom_range(0, 79) == 0);
      #1;
      took = in_valid && in_ready;
      if (flush) begin
        sb.delete();
      end else begin
        if (out_valid) begin
          if (sb.size() == 0) begin
            checks++; failures++;
            $display("FAIL rnd_spurious: got out_valid=1 expected 0 at step %0d", k);
          end else begin
            if (!sb[0].seen) begin
              check("rnd_latency", 64'(k), 64'(sb[0].due));
              sb[0].seen = 1'b1;
            end
            if (out_ready) begin
              e = sb.pop_front();
              check("rnd_data", 64'(out_data), 64'(e.data));
              check("rnd_tag", 64'(out_tag), 64'(e.tag));
              $display("rnd result data=0x%08h tag=%0d step=%0d", out_data, out_tag, k);
            end
          end
        end else if (sb.size() > 0 && !sb[0].seen && k >= sb[0].due) begin
          checks++; failures++;
          $display("FAIL rnd_missing: got out_valid=0 expected 1 at step %0d", k);
          void'(sb.pop_front());
        end
        if (took) begin
          e.data = ref_res(in_op, in_x, in_y);
          e.tag  = in_tag;
          e.due  = k + ref_lat(in_y);
          e.seen = 1'b0;
          sb.push_back(e);
        end
      end
      @(posedge clk); #1;
    end
    in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
    n = 0;
    while (busy && n < 100) begin @(posedge clk); #1; n++; end
    check("drain_idle", 64'(busy), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/div_issue_ctrl.md
Name: div_issue_ctrl

Overview:
- Issue/retire controller that sits in the EX stage directly upstream of the team's iterative radix-2 divider (DIV).
- Accepts one division request at a time from the EX decode logic through a valid/ready handshake, and registers the operands.
- Holds them stable and drives DIV until it signals complete, then picks the quotient or remainder and presents it downstream through a valid/ready handshake.
- Supports pipeline flush (exception/ertn) at any point.

Parameters:
- TAG_W, 5, width of destination-register tag carried with the request.

Ports:
- clk  input  1  system clock
- reset  input  1  asynchronous, active-high reset
- in_valid  input  1  request valid
- in_ready  output  1  controller can accept a request
- in_op  input  2  00 div.w, 01 mod.w, 10 div.wu, 11 mod.wu
- in_x  input  32  numerator
- in_y  input  32  denominator
- in_tag  input  TAG_W  destination tag
- flush  input  1  cancel the in-flight operation
- out_valid  output  1  result valid
- out_ready  input  1  downstream accepts result
- out_data  output  32  selected quotient or remainder
- out_tag  output  TAG_W  tag of the result
- busy  output  1  state != IDLE
- div_en  output  1  to DIV.div_en
- div_sign  output  1  to DIV.sign
- div_num  output  32  to DIV.divisor port (numerator; DIV port naming)
- div_den  output  32  to DIV.dividend port (denominator)
- div_resetn  output  1  to DIV.resetn (synchronous, active-low)
- div_result  input  64  from DIV: {quotient, remainder}
- div_complete  input  1  from DIV

Behaviour:
- States: IDLE, RUN, DONE, CLR. All registers are cleared asynchronously on reset.
- Reset values: state=IDLE, out_valid=0, out_data=0, out_tag=0, div_en=0, div_resetn=0 (DIV held in reset while reset is asserted).
- in_ready = (state==IDLE) | (state==DONE & out_ready), gated by ~flush.
- Accept = in_valid & in_ready. On accept, register op, x, y and tag; next state is RUN.
- Operand hold: div_num, div_den and div_sign come from those registers and are stable for the whole of RUN. div_sign = ~op[1].
- RUN: div_en=1. DIV takes 34 RUN cycles; complete is asserted in the 34th.
  - When div_complete is seen in RUN, register out_data = op[0] ? div_result[31:0] : div_result[63:32], latch out_tag, and go to DONE.
- Latency: accept at cycle T gives out_valid at cycle T+35.
- div_en drops to 0 in the cycle after complete. DIV's counter self-clears on complete, so back-to-back ops need no DIV reset.
- DONE: out_valid=1.
  - out_ready=1 & new accept: go to RUN (back-to-back).
  - out_ready=1 & no accept: go to IDLE.
  - out_ready=0: hold out_data and out_tag stable.
- flush, any state except IDLE:
  - Next state is CLR. out_valid=0 from the next cycle. Nothing is accepted in the flush cycle.
  - In CLR, div_resetn=0 for exactly one cycle so DIV's counter and partial state are cleared; div_en=0. Next state is IDLE.
- flush in IDLE: no effect except in_ready=0 for that cycle.
- reset asserted mid-operation: immediate return to IDLE, and the result is discarded.
- Unused DIV result bits are ignored. Divide-by-zero result is architecturally undefined; without the optional feature, whatever DIV returns is passed through.

Optional Feature:
- Macro: DIV_ZERO_FAST_EN.
- Defined: if the registered in_y==0 at accept, skip RUN and go straight to DONE the next cycle (latency 1).
  - out_data = 0 for div ops, in_x for mod ops.
  - div_en is never raised for that request.
- Undefined: zero divisor goes through the normal 35-cycle path and out_data is DIV's output.

Test Plan:
- div.w x=0xFFFFFFF9 (-7), y=2 -> out_valid at T+35, out_data=0xFFFFFFFD; mod.w with the same operands -> 0xFFFFFFFF.
- div.wu x=0xFFFFFFF9, y=2 -> 0x7FFFFFFC; mod.wu x=100, y=7 -> 2.
- Backpressure: out_ready=0 for 5 cycles after out_valid -> out_data and out_tag stable and in_ready=0; then out_ready=1 together with a new request (div.w 100/7) -> accepted that cycle, second result 14 at +35.
- Flush on the 10th RUN cycle -> one cycle of div_resetn=0, then IDLE. A following div.w 100/7 gives exactly 14 after 35 cycles, with no stale tag.
- Asynchronous reset mid-RUN -> out_valid=0 and state IDLE immediately, with no result emitted afterwards.
- With DIV_ZERO_FAST_EN: mod.w x=0x12345678, y=0 -> out_valid at T+1, out_data=0x12345678, div_en never high. Without it: the result arrives at T+35.
